// File: rtl/hinp_acq_sequencer.sv
// HINP4 acquisition control sequencer: force_rst -> settle -> armed window ->
// common_stop/veto_rst -> acq_clk burst -> release -> re-arm force_rst.
module hinp_acq_sequencer #(
    parameter int unsigned CW       = 16,
    parameter int unsigned T_FRST   = 100,
    parameter int unsigned T_SETTLE = 100,
    parameter int unsigned T_WINDOW = 1140,
    parameter int unsigned T_VETO   = 20,
    parameter int unsigned T_STOP   = 500,
    parameter int unsigned T_RDLY   = 10,
    parameter int unsigned T_HALF   = 80,
    parameter int unsigned N_ACQ    = 16,
    parameter int unsigned T_REL    = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic        start,
    input  logic        trigger,
    output logic        force_rst,
    output logic        global_cfd_en,
    output logic        common_stop,
    output logic        veto_rst,
    output logic        acq_clk,
    output logic        busy,
    output logic        timed_out,
    output logic        done,
    output logic [15:0] event_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_FRST, S_SETTLE, S_ARMED, S_STOP,
        S_RDWAIT, S_ACQ_HI, S_ACQ_LO, S_RELEASE, S_REFRST
    } state_t;

    // Counter reload values: each timed state runs for T_x cycles (cnt counts T_x-1 .. 0).
    localparam logic [CW-1:0] LD_FRST   = CW'(T_FRST - 1);
    localparam logic [CW-1:0] LD_SETTLE = CW'(T_SETTLE - 1);
    localparam bit            WIN_EN    = (T_WINDOW != 0);
    localparam logic [CW-1:0] LD_WIN    = WIN_EN ? CW'(T_WINDOW - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] LD_STOP   = CW'(T_STOP - 1);
    localparam logic [CW-1:0] VETO_TH   = CW'(T_STOP - 1 - T_VETO);
    localparam logic [CW-1:0] LD_RDLY   = CW'(T_RDLY - 1);
    localparam logic [CW-1:0] LD_HALF   = CW'(T_HALF - 1);
    localparam logic [CW-1:0] LD_REL    = CW'(T_REL - 1);
    localparam logic [7:0]    LD_ACQ    = 8'(N_ACQ - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          cnt_zero;
    logic          timed_out_d, done_d;
    logic [15:0]   event_cnt_d;
    logic          force_rst_d, global_cfd_en_d, common_stop_d, veto_rst_d, acq_clk_d, busy_d;

    assign cnt_zero = (cnt_q == {CW{1'b0}});

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CW{1'b0}};
            pcnt_q        <= 8'd0;
            force_rst     <= 1'b0;
            global_cfd_en <= 1'b0;
            common_stop   <= 1'b0;
            veto_rst      <= 1'b0;
            acq_clk       <= 1'b0;
            busy          <= 1'b0;
            timed_out     <= 1'b0;
            done          <= 1'b0;
            event_cnt     <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pcnt_q        <= pcnt_d;
            force_rst     <= force_rst_d;
            global_cfd_en <= global_cfd_en_d;
            common_stop   <= common_stop_d;
            veto_rst      <= veto_rst_d;
            acq_clk       <= acq_clk_d;
            busy          <= busy_d;
            timed_out     <= timed_out_d;
            done          <= done_d;
            event_cnt     <= event_cnt_d;
        end
    end

    // Next-state/counter logic, then outputs decoded from the next state so they
    // line up exactly with state occupancy.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_zero ? cnt_q : cnt_q - CW'(1);
        pcnt_d          = pcnt_q;
        timed_out_d     = timed_out;
        done_d          = 1'b0;
        event_cnt_d     = event_cnt;
        force_rst_d     = 1'b0;
        global_cfd_en_d = 1'b0;
        common_stop_d   = 1'b0;
        veto_rst_d      = 1'b0;
        acq_clk_d       = 1'b0;
        busy_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && run_en) begin
                    state_d = S_FRST;
                    cnt_d   = LD_FRST;
                end
            end
            S_FRST: begin
                if (cnt_zero) begin
                    state_d = S_SETTLE;
                    cnt_d   = LD_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_zero) begin
                    state_d = S_ARMED;
                    cnt_d   = LD_WIN;
                end
            end
            S_ARMED: begin
                if (!run_en) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (trigger) begin
                    state_d     = S_STOP;
                    cnt_d       = LD_STOP;
                    timed_out_d = 1'b0;
                end else if (WIN_EN && cnt_zero) begin
                    state_d     = S_STOP;
                    cnt_d       = LD_STOP;
                    timed_out_d = 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    state_d = S_RDWAIT;
                    cnt_d   = LD_RDLY;
                end
            end
            S_RDWAIT: begin
                if (cnt_zero) begin
                    state_d = S_ACQ_HI;
                    cnt_d   = LD_HALF;
                    pcnt_d  = LD_ACQ;
                end
            end
            S_ACQ_HI: begin
                if (cnt_zero) begin
                    state_d = S_ACQ_LO;
                    cnt_d   = LD_HALF;
                end
            end
            S_ACQ_LO: begin
                if (cnt_zero) begin
                    if (pcnt_q == 8'd0) begin
                        state_d = S_RELEASE;
                        cnt_d   = LD_REL;
                    end else begin
                        state_d = S_ACQ_HI;
                        cnt_d   = LD_HALF;
                        pcnt_d  = pcnt_q - 8'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (cnt_zero) begin
                    state_d = S_REFRST;
                    cnt_d   = LD_FRST;
                end
            end
            S_REFRST: begin
                if (cnt_zero) begin
                    done_d      = 1'b1;
                    event_cnt_d = event_cnt + 16'd1;
                    if (run_en) begin
                        state_d = S_SETTLE;
                        cnt_d   = LD_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = {CW{1'b0}};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        case (state_d)
            S_FRST, S_REFRST: force_rst_d     = 1'b1;
            S_ARMED:          global_cfd_en_d = 1'b1;
            S_STOP: begin
                common_stop_d = 1'b1;
                veto_rst_d    = (cnt_d <= VETO_TH);
            end
            S_RDWAIT, S_ACQ_LO: veto_rst_d = 1'b1;
            S_ACQ_HI: begin
                veto_rst_d = 1'b1;
                acq_clk_d  = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_hinp_acq_sequencer.sv
// Directed bench for hinp_acq_sequencer using small timing parameters.
module tb_hinp_acq_sequencer;

    localparam int unsigned CW = 16;

    logic        clk = 1'b0;
    logic        rst_n, run_en, start, trigger;
    logic        force_rst, global_cfd_en, common_stop, veto_rst, acq_clk;
    logic        busy, timed_out, done;
    logic [15:0] event_cnt;

    always #5 clk = ~clk;

    hinp_acq_sequencer #(
        .CW(CW), .T_FRST(3), .T_SETTLE(2), .T_WINDOW(20), .T_VETO(2), .T_STOP(5),
        .T_RDLY(2), .T_HALF(2), .N_ACQ(4), .T_REL(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .start(start), .trigger(trigger),
        .force_rst(force_rst), .global_cfd_en(global_cfd_en), .common_stop(common_stop),
        .veto_rst(veto_rst), .acq_clk(acq_clk), .busy(busy), .timed_out(timed_out),
        .done(done), .event_cnt(event_cnt)
    );

    // Bit order: force_rst, global_cfd_en, common_stop, veto_rst, acq_clk, busy, done
    localparam int B_DONE = 0, B_ACQ = 2, B_STOP = 4, B_CFD = 5;
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_FRST   = 7'b1000010;
    localparam logic [6:0] O_QUIET  = 7'b0000010;
    localparam logic [6:0] O_ARMED  = 7'b0100010;
    localparam logic [6:0] O_STOP   = 7'b0010010;
    localparam logic [6:0] O_STOPV  = 7'b0011010;
    localparam logic [6:0] O_VETO   = 7'b0001010;
    localparam logic [6:0] O_ACQ    = 7'b0001110;
    localparam logic [6:0] O_DONE   = 7'b0000001;

    logic [6:0] outs;
    assign outs = {force_rst, global_cfd_en, common_stop, veto_rst, acq_clk, busy, done};

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    typedef struct {
        string      name;
        logic       run_en;
        logic       start;
        logic       trigger;
        int         len;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic re, logic st, logic tr, int len, logic [6:0] exp);
        vec_t v;
        v.name = name; v.run_en = re; v.start = st; v.trigger = tr; v.len = len; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) at falling edges until an output bit reaches val.
    task automatic wait_level(input int idx, input logic val, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (outs[idx] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(outs[idx]), 32'(val));
    endtask

    // Count consecutive high cycles of an output bit, starting at a high cycle.
    task automatic high_len(input int idx, input int budget, output int n);
        n = 1;
        @(negedge clk);
        while (outs[idx] === 1'b1 && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        run_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stop_seen;

        rst_n = 1'b0; run_en = 1'b0; start = 1'b0; trigger = 1'b0;

        // Reset / idle: nothing moves without start, even with trigger wiggling.
        #12;
        check("reset_outs", 32'({outs, timed_out, event_cnt}), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        run_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            trigger = i[0];
            @(negedge clk);
            check("idle_hold", 32'({outs, timed_out, event_cnt}), 32'd0);
        end
        trigger = 1'b0;

        // Triggered event, cycle 0 = start cycle; run_en dropped after the trigger.
        add("c0_start",   1, 1, 0, 1, O_IDLE);
        add("frst",       1, 0, 0, 3, O_FRST);
        add("settle",     1, 0, 0, 2, O_QUIET);
        add("armed",      1, 0, 0, 4, O_ARMED);
        add("armed_trig", 1, 0, 1, 1, O_ARMED);
        add("stop",       0, 0, 1, 2, O_STOP);
        add("stop_veto",  0, 0, 0, 3, O_STOPV);
        add("rdwait",     0, 1, 0, 2, O_VETO);
        for (int p = 0; p < 4; p++) begin
            add("acq_hi", 0, 0, 0, 2, O_ACQ);
            add("acq_lo", 0, 0, 0, 2, O_VETO);
        end
        add("release",    0, 0, 1, 3, O_QUIET);
        add("refrst",     0, 0, 0, 3, O_FRST);
        add("done",       0, 0, 0, 1, O_DONE);
        add("idle_after", 0, 0, 0, 5, O_IDLE);

        @(posedge clk);
        #1;
        foreach (vecs[r]) begin
            run_en  = vecs[r].run_en;
            start   = vecs[r].start;
            trigger = vecs[r].trigger;
            for (int i = 0; i < vecs[r].len; i++) begin
                @(negedge clk);
                check(vecs[r].name, 32'(outs), 32'(vecs[r].exp));
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0; trigger = 1'b0;
        check("trig_event_cnt", 32'(event_cnt), 32'd1);
        check("trig_timed_out", 32'(timed_out), 32'd0);

        // Timeout: no trigger, window of 20 cycles.
        start_run();
        wait_level(B_CFD, 1'b1, 30, "to_arm");
        high_len(B_CFD, 100, n);
        check("to_window", 32'(n), 32'd20);
        check("to_stop_rise", 32'(common_stop), 32'd1);
        check("to_flag", 32'(timed_out), 32'd1);
        run_en = 1'b0;
        wait_level(B_DONE, 1'b1, 100, "to_done");
        check("to_event_cnt", 32'(event_cnt), 32'd2);

        // Trigger on the expiry cycle counts as a trigger.
        start_run();
        wait_level(B_CFD, 1'b1, 30, "sim_arm");
        repeat (19) @(negedge clk);
        check("sim_armed_last", 32'(global_cfd_en), 32'd1);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("sim_stop", 32'({global_cfd_en, common_stop}), 32'b01);
        check("sim_flag", 32'(timed_out), 32'd0);
        run_en = 1'b0;
        wait_level(B_DONE, 1'b1, 100, "sim_done");

        // run_en drop wins over trigger in ARMED.
        start_run();
        wait_level(B_CFD, 1'b1, 30, "abort_arm");
        repeat (2) @(negedge clk);
        run_en  = 1'b0;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("abort_idle", 32'(outs), 32'(O_IDLE));
        stop_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (common_stop !== 1'b0 || busy !== 1'b0) stop_seen++;
        end
        check("abort_no_stop", 32'(stop_seen), 32'd0);
        check("abort_event_cnt", 32'(event_cnt), 32'd3);

        // Async reset clears event_cnt, then a continuous run of three events.
        #2 rst_n = 1'b0;
        #1 check("rst_event_cnt", 32'({outs, timed_out, event_cnt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        start_run();
        for (int e = 0; e < 3; e++) begin
            wait_level(B_CFD, 1'b1, 60, "cont_arm");
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            check("cont_stop", 32'(common_stop), 32'd1);
            if (e == 2) run_en = 1'b0;
            wait_level(B_DONE, 1'b1, 200, "cont_done");
            if (e < 2) begin
                check("cont_resettle", 32'(outs), 32'(O_QUIET | O_DONE));
                repeat (2) @(negedge clk);
                check("cont_rearm", 32'(outs), 32'(O_ARMED));
            end else begin
                check("cont_last_idle", 32'(outs), 32'(O_DONE));
            end
        end
        repeat (3) @(negedge clk);
        check("cont_done_pulses", 32'(done_seen), 32'd3);
        check("cont_event_cnt", 32'(event_cnt), 32'd3);

        // Async reset during the second acq_clk high phase.
        start_run();
        wait_level(B_CFD, 1'b1, 60, "mr_arm");
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        run_en  = 1'b1;
        wait_level(B_ACQ, 1'b1, 60, "mr_acq1");
        wait_level(B_ACQ, 1'b0, 10, "mr_acq1_lo");
        wait_level(B_ACQ, 1'b1, 10, "mr_acq2");
        done_seen = 0;
        rst_n = 1'b0;
        #1;
        check("mr_reset_now", 32'({outs, timed_out, event_cnt}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stop_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outs !== O_IDLE || event_cnt !== 16'd0) stop_seen++;
        end
        check("mr_stays_idle", 32'(stop_seen), 32'd0);
        check("mr_no_done", 32'(done_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
